// File: rtl/seq_011_pkg.sv
// Shared definitions for the 011-preamble serial transmitter and its detector bench.
// State encodings and the preamble pattern live here so both sides agree on them.
package seq_011_pkg;

  localparam logic [2:0] EncIdle = 3'd0;
  localparam logic [2:0] EncPre0 = 3'd1;
  localparam logic [2:0] EncPre1 = 3'd2;
  localparam logic [2:0] EncPre2 = 3'd3;
  localparam logic [2:0] EncData = 3'd4;
  localparam logic [2:0] EncPar  = 3'd5;

  // Sent MSB first: bit 2 goes out in PRE0, bit 0 in PRE2.
  localparam logic [2:0] Preamble = 3'b011;

  typedef enum logic [2:0] {
    StIdle = EncIdle,
    StPre0 = EncPre0,
    StPre1 = EncPre1,
    StPre2 = EncPre2,
    StData = EncData,
    StPar  = EncPar
  } state_e;

  function automatic int unsigned frame_len(input int unsigned data_w, input bit parity_en);
    return 3 + data_w + {31'd0, parity_en};
  endfunction

endpackage

// File: rtl/seq_011_tx_piso_shift.sv
// Parallel-in, serial-out shift register: loads a word, then presents it MSB first.
module piso_shift #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_msb
);

  logic [DATA_W-1:0] r_sreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
    end else if (i_shift) begin
      r_sreg <= r_sreg << 1;
    end
  end

  assign o_msb = r_sreg[DATA_W-1];

endmodule

// File: rtl/seq_011_tx.sv
// Serial frame transmitter: 011 preamble, MSB-first payload, optional even parity.
// All outputs are registered; each state's line value is set on the edge that enters it.
module seq_011_tx
  import seq_011_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      CntW    = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(DATA_W);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_par;
  logic            r_dout;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;

  logic w_load;
  logic w_shift;
  logic w_msb;

  // r_cnt counts payload bits still to be shown after the one now on the line.
  always_comb begin
    w_load  = (r_state == StIdle) && start;
    w_shift = (r_state == StPre2) || ((r_state == StData) && (r_cnt != '0));
  end

  piso_shift #(
    .DATA_W (DATA_W)
  ) u_piso_shift (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (data),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_dout  <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          r_dout <= 1'b1;
          if (start) begin
            r_state <= StPre0;
            r_dout  <= Preamble[2];
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= CntLoad;
            r_par   <= ^data;
          end
        end
        StPre0: begin
          r_state <= StPre1;
          r_dout  <= Preamble[1];
        end
        StPre1: begin
          r_state <= StPre2;
          r_dout  <= Preamble[0];
        end
        StPre2: begin
          r_state <= StData;
          r_dout  <= w_msb;
          r_cnt   <= r_cnt - CntOne;
          r_done  <= !PARITY_EN && (r_cnt == CntOne);
        end
        StData: begin
          if (r_cnt != '0) begin
            r_dout <= w_msb;
            r_cnt  <= r_cnt - CntOne;
            r_done <= !PARITY_EN && (r_cnt == CntOne);
          end else if (PARITY_EN) begin
            r_state <= StPar;
            r_dout  <= r_par;
            r_done  <= 1'b1;
          end else begin
            r_state <= StIdle;
            r_dout  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        StPar: begin
          r_state <= StIdle;
          r_dout  <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_dout  <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign dout  = r_dout;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_seq_011_tx.sv
// Scoreboard bench: a parity and a no-parity transmitter, each with an expected-bit queue
// filled at acceptance and drained as frame bits appear; dout also feeds an 011 detector.
module tb_seq_011_tx;
  import seq_011_pkg::*;

  localparam int unsigned DW = 8;

  typedef struct packed {
    logic dout;
    logic done;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start0, start1;
  logic [DW-1:0] data0, data1;
  logic          ready0, dout0, busy0, done0;
  logic          ready1, dout1, busy1, done1;

  exp_t q0[$];
  exp_t q1[$];
  int   rem0, rem1;
  int   n_tests, n_fail;
  bit   mon_en;
  int   busy_cnt1, done_cnt0, done_cnt1, match_cnt0;

  logic [1:0] hist0;
  logic [1:0] ref_h0;
  logic       det0;

  seq_011_tx #(
    .DATA_W    (DW),
    .PARITY_EN (1'b1)
  ) u_dut_par (
    .clk   (clk),
    .reset (reset),
    .start (start0),
    .data  (data0),
    .ready (ready0),
    .dout  (dout0),
    .busy  (busy0),
    .done  (done0)
  );

  seq_011_tx #(
    .DATA_W    (DW),
    .PARITY_EN (1'b0)
  ) u_dut_nopar (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .data  (data1),
    .ready (ready1),
    .dout  (dout1),
    .busy  (busy1),
    .done  (done1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [DW-1:0] d, input bit par_en);
    logic [15:0] v;
    v        = '0;
    v[15:13] = Preamble;
    v[12:5]  = d;
    if (par_en) v[4] = ^d;
    return v;
  endfunction

  // Reference: a frame's bits are queued on the edge the transmitter should accept it.
  always @(posedge clk) begin : model0
    logic [15:0] fb;
    int          len;
    exp_t        e;
    if (reset) begin
      q0.delete();
      rem0 = 0;
    end else if (rem0 == 0 && start0) begin
      fb  = frame_bits(data0, 1'b1);
      len = int'(frame_len(DW, 1'b1));
      for (int i = 0; i < len; i++) begin
        e.dout = fb[15-i];
        e.done = (i == len - 1);
        q0.push_back(e);
      end
      rem0 = len;
    end else if (rem0 > 0) begin
      rem0--;
    end
  end

  always @(posedge clk) begin : model1
    logic [15:0] fb;
    int          len;
    exp_t        e;
    if (reset) begin
      q1.delete();
      rem1 = 0;
    end else if (rem1 == 0 && start1) begin
      fb  = frame_bits(data1, 1'b0);
      len = int'(frame_len(DW, 1'b0));
      for (int i = 0; i < len; i++) begin
        e.dout = fb[15-i];
        e.done = (i == len - 1);
        q1.push_back(e);
      end
      rem1 = len;
    end else if (rem1 > 0) begin
      rem1--;
    end
  end

  // Downstream 011 detector on the parity transmitter's line.
  always @(posedge clk) hist0 <= {hist0[0], dout0};
  assign det0 = ({hist0, dout0} == Preamble);

  always @(negedge clk) begin : mon0
    exp_t e;
    logic exp_bit, ref_match;
    if (mon_en) begin
      check_eq("ready0", ready0, rem0 == 0);
      check_eq("busy0", busy0, rem0 != 0);
      if (rem0 != 0) begin
        e = 2'bxx;
        if (q0.size() != 0) e = q0.pop_front();
        check_eq("dout0", dout0, e.dout);
        check_eq("done0", done0, e.done);
        exp_bit = e.dout;
        if (det0) match_cnt0++;
      end else begin
        check_eq("idle_dout0", dout0, 1);
        check_eq("idle_done0", done0, 0);
        exp_bit = 1'b1;
      end
      if (done0) done_cnt0++;
      ref_match = ({ref_h0, exp_bit} == Preamble);
      ref_h0    = {ref_h0[0], exp_bit};
      check_eq("det0", det0, ref_match);
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (mon_en) begin
      check_eq("ready1", ready1, rem1 == 0);
      check_eq("busy1", busy1, rem1 != 0);
      if (rem1 != 0) begin
        e = 2'bxx;
        if (q1.size() != 0) e = q1.pop_front();
        check_eq("dout1", dout1, e.dout);
        check_eq("done1", done1, e.done);
      end else begin
        check_eq("idle_dout1", dout1, 1);
        check_eq("idle_done1", done1, 0);
      end
      if (busy1) busy_cnt1++;
      if (done1) done_cnt1++;
    end
  end

  task automatic wait_idle0();
    for (int i = 0; i < 64 && rem0 != 0; i++) @(negedge clk);
    if (rem0 != 0) check_eq("idle0_timeout", rem0, 0);
  endtask

  task automatic wait_idle1();
    for (int i = 0; i < 64 && rem1 != 0; i++) @(negedge clk);
    if (rem1 != 0) check_eq("idle1_timeout", rem1, 0);
  endtask

  // Returns on the negedge of frame cycle 1; data is scrambled after acceptance.
  task automatic send0(input logic [DW-1:0] d);
    wait_idle0();
    @(negedge clk);
    start0 = 1'b1;
    data0  = d;
    @(negedge clk);
    start0 = 1'b0;
    data0  = DW'($urandom);
  endtask

  task automatic send1(input logic [DW-1:0] d);
    wait_idle1();
    @(negedge clk);
    start1 = 1'b1;
    data1  = d;
    @(negedge clk);
    start1 = 1'b0;
    data1  = DW'($urandom);
  endtask

  initial begin
    int dc;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rem0 = 0;
    rem1 = 0;
    ref_h0 = 2'b11;
    busy_cnt1 = 0;
    done_cnt0 = 0;
    done_cnt1 = 0;
    match_cnt0 = 0;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    data0  = '0;
    data1  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready0", ready0, 1);
    check_eq("rst_dout0", dout0, 1);
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_done0", done0, 0);
    check_eq("rst_ready1", ready1, 1);
    check_eq("rst_dout1", dout1, 1);
    reset  = 1'b0;
    mon_en = 1'b1;

    // A5 with parity, with a stray start pulse mid-frame.
    send0(8'hA5);
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle0();

    // 00 without parity: 11 busy cycles, one done.
    wait_idle1();
    busy_cnt1 = 0;
    done_cnt1 = 0;
    send1(8'h00);
    wait_idle1();
    check_eq("busy_len1", busy_cnt1, 11);
    check_eq("done_cnt1", done_cnt1, 1);

    // FF loopback: exactly one in-frame 011 match, from the preamble.
    match_cnt0 = 0;
    send0(8'hFF);
    wait_idle0();
    check_eq("ff_matches", match_cnt0, 1);

    // Start held high: back-to-back frames with one idle cycle between.
    @(negedge clk);
    start0 = 1'b1;
    repeat (40) begin
      @(negedge clk);
      data0 = DW'($urandom);
    end
    start0 = 1'b0;
    wait_idle0();

    // Reset during frame cycle 5 aborts without a done pulse.
    send0(8'h5A);
    repeat (4) @(negedge clk);
    dc    = done_cnt0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_ready0", ready0, 1);
    check_eq("abort_dout0", dout0, 1);
    check_eq("abort_busy0", busy0, 0);
    repeat (12) @(negedge clk);
    check_eq("abort_no_done", done_cnt0, dc);
    send0(8'h3C);
    wait_idle0();

    // Reset wins over start on the same edge.
    @(negedge clk);
    reset  = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    check_eq("rst_prio_busy0", busy0, 0);
    check_eq("rst_prio_busy1", busy1, 0);

    for (int i = 0; i < 6; i++) begin
      send0(DW'($urandom));
      send1(DW'($urandom));
    end
    wait_idle0();
    wait_idle1();
    repeat (3) @(negedge clk);
    check_eq("q0_empty", q0.size(), 0);
    check_eq("q1_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
